bram_incr_ctrl: RTL

//   Read-modify-write sequencer that increments one BRAM word per request, for

---
 rtl/bram_incr_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bram_incr_ctrl.sv
// ---------------------------------------------------------------------------
// bram_incr_ctrl
//   Read-modify-write sequencer that adds one to a single BRAM word for each
//   accepted request (histogram / event counters). It can also zero every
//   address with a clear sweep. Requests and clear sweeps are handled one at
//   a time, and the block drives the only port of a synchronous single-port
//   BRAM.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting; clr has priority over req_valid
//   READ  | read enable issued to the latched address
//   WAIT  | read data valid; the half_adder adds one and the result is held
//   WRITE | incremented (or saturated/wrapped) value written back, done pulse
//   CLEAR | zero-write sweep over every address, one address per cycle
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     increment handshake; req_addr captured on accept
//   clr                 level request to clear the whole BRAM (sampled in IDLE)
//   busy                high outside IDLE
//   done, ovf           WRITE-cycle pulses; ovf when the increment carried out
//   clr_done            pulse in the cycle that writes the last address
//   bram_*              single-port BRAM interface, read latency 1
// ---------------------------------------------------------------------------

// half_adder: sum = a + b. The sum is high-Z and c_out is low while the block
// is disabled.
module half_adder #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 enable,
    output logic [DATAWIDTH-1:0] sum,
    output logic                 c_out
);
    logic [DATAWIDTH:0] full;

    assign full  = {1'b0, a} + {1'b0, b};
    assign sum   = enable ? full[DATAWIDTH-1:0] : {DATAWIDTH{1'bz}};
    assign c_out = enable & full[DATAWIDTH];
endmodule

module bram_incr_ctrl #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDRWIDTH-1:0] req_addr,
    input  logic                 clr,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic                 clr_done,
    output logic                 bram_en,
    output logic                 bram_we,
    output logic [ADDRWIDTH-1:0] bram_addr,
    output logic [DATAWIDTH-1:0] bram_wdata,
    input  logic [DATAWIDTH-1:0] bram_rdata
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;

    localparam logic [ADDRWIDTH-1:0] ADDR_LAST = {ADDRWIDTH{1'b1}};
    localparam logic [ADDRWIDTH-1:0] ADDR_ONE  = {{(ADDRWIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATAWIDTH-1:0] DATA_ONE  = {{(DATAWIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATAWIDTH-1:0] OVF_VALUE = (SATURATE != 0) ? {DATAWIDTH{1'b1}}
                                                                  : {DATAWIDTH{1'b0}};

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic                 cout_q;
    logic                 ha_en;
    logic [DATAWIDTH-1:0] ha_sum;
    logic                 ha_cout;

    assign ha_en = (state == S_WAIT);

    half_adder #(.DATAWIDTH(DATAWIDTH)) u_half_adder (
        .a      (bram_rdata),
        .b      (DATA_ONE),
        .enable (ha_en),
        .sum    (ha_sum),
        .c_out  (ha_cout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (clr)
                    state_nxt = S_CLEAR;
                else if (req_valid)
                    state_nxt = S_READ;
            end
            S_READ:  state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_IDLE;
            S_CLEAR: begin
                if (bram_addr == ADDR_LAST)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // bram_addr doubles as the latched request address and the sweep
    // counter. bram_addr and bram_wdata are registers so they hold their
    // values while the port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bram_addr  <= '0;
            bram_wdata <= '0;
            cout_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (clr) begin
                        bram_addr  <= '0;
                        bram_wdata <= '0;
                    end else if (req_valid) begin
                        bram_addr <= req_addr;
                    end
                end
                S_WAIT: begin
                    // The sum is sampled only here, while the adder drives it.
                    cout_q     <= ha_cout;
                    bram_wdata <= ha_cout ? OVF_VALUE : ha_sum;
                end
                S_CLEAR: begin
                    if (bram_addr != ADDR_LAST)
                        bram_addr <= bram_addr + ADDR_ONE;
                end
                default: ;
            endcase
        end
    end

    // Strobes are decoded from state, so an async reset drops them at once.
    assign busy      = (state != S_IDLE);
    assign req_ready = (state == S_IDLE) & ~clr;
    assign bram_en   = (state == S_READ) | (state == S_WRITE) | (state == S_CLEAR);
    assign bram_we   = (state == S_WRITE) | (state == S_CLEAR);
    assign done      = (state == S_WRITE);
    assign ovf       = (state == S_WRITE) & cout_q;
    assign clr_done  = (state == S_CLEAR) & (bram_addr == ADDR_LAST);
endmodule
